fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 167 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Front-end fetch sequencer: boot, run, drain and halt control for the PC and IF/ID stage,
// with zero-cycle hazard response, saturating perf counters and a stall watchdog.
module fetch_sequencer #(
  parameter int BOOT_CYCLES  = 4,
  parameter int DRAIN_CYCLES = 4,
  parameter int MAX_STALL    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt,
  input  logic        PCSrc_final,
  input  logic        load_use,
  output logic        pc_rst_n,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        fetch_valid,
  output logic [2:0]  state,
  output logic [15:0] perf_stalls,
  output logic [15:0] perf_flushes,
  output logic        stall_err
);

  localparam int CNT_MAX = (BOOT_CYCLES > DRAIN_CYCLES) ? BOOT_CYCLES : DRAIN_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int STL_W   = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;

  localparam logic [CNT_W-1:0] BOOT_LOAD  = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [STL_W-1:0] STALL_LIM  = STL_W'(MAX_STALL);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BOOT   = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [STL_W-1:0] r_stall_run;
  logic [15:0]      r_perf_stalls;
  logic [15:0]      r_perf_flushes;
  logic             r_stall_err;

  logic w_run;
  logic w_redirect;
  logic w_stall;
  logic w_launch;
  logic w_cnt_zero;

  // Hazard decode in RUN: halt > redirect > load-use.
  assign w_run      = (r_state == S_RUN);
  assign w_redirect = w_run & ~halt & PCSrc_final;
  assign w_stall    = w_run & ~halt & ~PCSrc_final & load_use;
  assign w_launch   = (r_state == S_IDLE) & start;
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start)      w_next = S_BOOT;
      S_BOOT:   if (w_cnt_zero) w_next = S_RUN;
      S_RUN:    if (halt)       w_next = S_DRAIN;
      S_DRAIN:  if (w_cnt_zero) w_next = S_HALTED;
      S_HALTED: if (!start)     w_next = S_IDLE;
      default:                  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    pc_rst_n    = 1'b1;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b1;
    idex_flush  = 1'b0;
    fetch_valid = 1'b0;
    case (r_state)
      S_BOOT, S_DRAIN, S_HALTED: begin
      end
      S_RUN: begin
        if (halt) begin
          // A redirect coincident with halt still loads its target into the PC.
          pc_en      = PCSrc_final;
          idex_flush = PCSrc_final;
        end else if (PCSrc_final) begin
          pc_en      = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          ifid_flush = 1'b0;
          idex_flush = 1'b1;
        end else begin
          pc_en       = 1'b1;
          ifid_en     = 1'b1;
          ifid_flush  = 1'b0;
          fetch_valid = 1'b1;
        end
      end
      default: begin
        pc_rst_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE:          if (start)       r_cnt <= BOOT_LOAD;
        S_RUN:           if (halt)        r_cnt <= DRAIN_LOAD;
        S_BOOT, S_DRAIN: if (!w_cnt_zero) r_cnt <= r_cnt - 1'b1;
        default:         r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_stalls  <= '0;
      r_perf_flushes <= '0;
    end else if (w_launch) begin
      r_perf_stalls  <= '0;
      r_perf_flushes <= '0;
    end else begin
      if (w_stall && (r_perf_stalls != '1))     r_perf_stalls  <= r_perf_stalls + 1'b1;
      if (w_redirect && (r_perf_flushes != '1)) r_perf_flushes <= r_perf_flushes + 1'b1;
    end
  end

  // Watchdog: run length of back-to-back stalls; error is sticky until reset or relaunch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_run <= '0;
      r_stall_err <= 1'b0;
    end else begin
      if (w_stall) begin
        if (r_stall_run != STALL_LIM) r_stall_run <= r_stall_run + 1'b1;
      end else begin
        r_stall_run <= '0;
      end
      if (w_launch) begin
        r_stall_err <= 1'b0;
      end else if (w_stall && ((int'(r_stall_run) + 1) >= MAX_STALL)) begin
        r_stall_err <= 1'b1;
      end
    end
  end

  assign state        = r_state;
  assign perf_stalls  = r_perf_stalls;
  assign perf_flushes = r_perf_flushes;
  assign stall_err    = r_stall_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by randomized
// traffic, all compared against a cycle-level behavioural model of the sequencer rules.
module tb_fetch_sequencer;

  localparam int BOOT  = 4;
  localparam int DRAIN = 4;
  localparam int MAXS  = 8;

  logic        clk = 1'b0;
  logic        rst, start, halt, PCSrc_final, load_use;
  logic        pc_rst_n, pc_en, ifid_en, ifid_flush, idex_flush, fetch_valid;
  logic [2:0]  state;
  logic [15:0] perf_stalls, perf_flushes;
  logic        stall_err;

  int n_pass  = 0;
  int n_total = 0;

  // Model: 0 idle, 1 boot, 2 run, 3 drain, 4 halted.
  int m_state, m_cnt, m_ps, m_pf, m_srun;
  bit m_err;
  bit m_pf_known;

  fetch_sequencer #(
    .BOOT_CYCLES (BOOT),
    .DRAIN_CYCLES(DRAIN),
    .MAX_STALL   (MAXS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .halt        (halt),
    .PCSrc_final (PCSrc_final),
    .load_use    (load_use),
    .pc_rst_n    (pc_rst_n),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .fetch_valid (fetch_valid),
    .state       (state),
    .perf_stalls (perf_stalls),
    .perf_flushes(perf_flushes),
    .stall_err   (stall_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit exceeded");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_ps = 0; m_pf = 0; m_srun = 0;
    m_err = 1'b0; m_pf_known = 1'b1;
  endtask

  task automatic model_update(input logic s, input logic h, input logic p, input logic l);
    bit stall_cycle;
    stall_cycle = (m_state == 2) && !h && !p && l;
    case (m_state)
      0: if (s) begin
        m_state = 1; m_cnt = BOOT - 1;
        m_ps = 0; m_pf = 0; m_err = 1'b0; m_pf_known = 1'b1;
      end
      1: if (m_cnt == 0) m_state = 2; else m_cnt--;
      2: begin
        if (h) begin
          m_state = 3; m_cnt = DRAIN - 1;
          if (p) m_pf_known = 1'b0;
        end else if (p) begin
          if (m_pf < 16'hFFFF) m_pf++;
        end else if (l) begin
          if (m_ps < 16'hFFFF) m_ps++;
        end
      end
      3: if (m_cnt == 0) m_state = 4; else m_cnt--;
      4: if (!s) m_state = 0;
      default: m_state = 0;
    endcase
    if (stall_cycle) begin
      m_srun++;
      if (m_srun >= MAXS) m_err = 1'b1;
    end else begin
      m_srun = 0;
    end
  endtask

  task automatic check_outputs(input string ctx);
    logic e_rstn = 1'b0, e_pc = 1'b0, e_ifen = 1'b0, e_iff = 1'b0, e_idf = 1'b0, e_fv = 1'b0;
    bit c_rstn = 1'b1, c_ifen = 1'b1, c_iff = 1'b1, c_idf = 1'b1, c_fv = 1'b1;
    case (m_state)
      0: begin e_rstn = 1'b0; e_iff = 1'b1; end
      1: begin e_rstn = 1'b1; e_iff = 1'b1; c_idf = 1'b0; end
      2: begin
        e_rstn = 1'b1;
        if (halt) begin
          e_pc = PCSrc_final; e_iff = 1'b1; c_ifen = 1'b0; c_idf = 1'b0;
        end else if (PCSrc_final) begin
          e_pc = 1'b1; e_iff = 1'b1; e_idf = 1'b1; c_ifen = 1'b0;
        end else if (load_use) begin
          e_idf = 1'b1; c_iff = 1'b0; c_fv = 1'b0;
        end else begin
          e_pc = 1'b1; e_ifen = 1'b1; e_fv = 1'b1;
        end
      end
      default: begin e_iff = 1'b1; c_rstn = 1'b0; c_idf = 1'b0; end
    endcase
    if (c_rstn) chk({ctx, ".pc_rst_n"}, 32'(pc_rst_n), 32'(e_rstn));
    chk({ctx, ".pc_en"}, 32'(pc_en), 32'(e_pc));
    if (c_ifen) chk({ctx, ".ifid_en"}, 32'(ifid_en), 32'(e_ifen));
    if (c_iff)  chk({ctx, ".ifid_flush"}, 32'(ifid_flush), 32'(e_iff));
    if (c_idf)  chk({ctx, ".idex_flush"}, 32'(idex_flush), 32'(e_idf));
    if (c_fv)   chk({ctx, ".fetch_valid"}, 32'(fetch_valid), 32'(e_fv));
    chk({ctx, ".state"}, 32'(state), 32'(m_state));
    chk({ctx, ".perf_stalls"}, 32'(perf_stalls), 32'(m_ps));
    if (m_pf_known) chk({ctx, ".perf_flushes"}, 32'(perf_flushes), 32'(m_pf));
    chk({ctx, ".stall_err"}, 32'(stall_err), 32'(m_err));
  endtask

  // Inputs change just after a rising edge; outputs are checked 1 time unit later.
  task automatic step(input logic s, input logic h, input logic p, input logic l, input string ctx);
    start = s; halt = h; PCSrc_final = p; load_use = l;
    #1;
    check_outputs(ctx);
    @(posedge clk);
    model_update(s, h, p, l);
    #1;
  endtask

  // Reset pulse strictly between two rising edges.
  task automatic async_reset(input string ctx);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs(ctx);
    #1;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    int lu_pct;
    rst = 1'b0; start = 1'b0; halt = 1'b0; PCSrc_final = 1'b0; load_use = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1'b1;

    step(1'b0, 1'b0, 1'b0, 1'b0, "idle_wait");
    step(1'b0, 1'b1, 1'b1, 1'b1, "idle_wait");

    // Boot with hazard inputs that must be ignored.
    step(1'b1, 1'b0, 1'b0, 1'b0, "launch");
    for (int i = 0; i < BOOT; i++)
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "boot");
    step(1'b1, 1'b0, 1'b0, 1'b0, "run_first");

    step(1'b1, 1'b0, 1'b1, 1'b1, "redirect");
    step(1'b1, 1'b0, 1'b0, 1'b0, "post_redirect");

    for (int i = 0; i < MAXS; i++) step(1'b1, 1'b0, 1'b0, 1'b1, "watchdog");
    step(1'b1, 1'b0, 1'b0, 1'b0, "wd_after");
    step(1'b1, 1'b0, 1'b0, 1'b0, "wd_sticky");

    step(1'b1, 1'b1, 1'b1, 1'b0, "halt_redirect");
    for (int i = 0; i < DRAIN; i++) step(1'b1, 1'b0, 1'b0, 1'b0, "drain");
    step(1'b1, 1'b0, 1'b0, 1'b0, "halted");
    step(1'b1, 1'b0, 1'b0, 1'b0, "halted_hold");
    step(1'b0, 1'b0, 1'b0, 1'b0, "to_idle");
    step(1'b0, 1'b0, 1'b0, 1'b0, "idle");

    step(1'b1, 1'b0, 1'b0, 1'b0, "relaunch");
    for (int i = 0; i < BOOT; i++) step(1'b1, 1'b0, 1'b0, 1'b0, "boot2");
    step(1'b1, 1'b0, 1'b0, 1'b1, "stall2");
    step(1'b1, 1'b1, 1'b0, 1'b0, "halt2");
    step(1'b1, 1'b0, 1'b0, 1'b0, "drain2");
    async_reset("async_drain");
    step(1'b0, 1'b0, 1'b0, 1'b0, "post_async");

    step(1'b1, 1'b0, 1'b0, 1'b0, "launch3");
    for (int i = 0; i < BOOT; i++) step(1'b1, 1'b0, 1'b0, 1'b0, "boot3");
    force dut.r_perf_stalls = 16'hFFFE;
    #1;
    release dut.r_perf_stalls;
    m_ps = 16'hFFFE;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, "saturate");
    step(1'b1, 1'b0, 1'b0, 1'b0, "sat_after");
    step(1'b1, 1'b0, 1'b0, 1'b1, "stall_mid_rst");
    async_reset("async_stall");

    for (int i = 0; i < 800; i++) begin
      lu_pct = ((i / 100) % 2 == 1) ? 92 : 30;
      step(1'($urandom_range(0, 19) != 0),
           1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 99) < lu_pct),
           "rand");
      if ($urandom_range(0, 149) == 0) async_reset("rand_async");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
